// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-stage branch predictor: counter encodings,
// PC step and the saturating miss-count limit.
package branch_predictor_pkg;

  localparam logic [1:0]  BP_CTR_WNT = 2'b01;
  localparam logic [1:0]  BP_CTR_WT  = 2'b10;
  localparam logic [1:0]  BP_CTR_MAX = 2'b11;
  localparam logic [1:0]  BP_CTR_MIN = 2'b00;
  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] COUNT_MAX  = 32'hFFFF_FFFF;

  // No delay slot: fall-through is always the next word, wrapping at 2^32.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter with parallel load; resets to weakly
// not-taken.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [1:0] load_val,
  output logic [1:0] ctr
);

  logic [1:0] ctr_r;

  // Counter state: load has priority, then saturating increment/decrement.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      ctr_r <= BP_CTR_WNT;
    end else if (load) begin
      ctr_r <= load_val;
    end else if (inc && (ctr_r != BP_CTR_MAX)) begin
      ctr_r <= ctr_r + 2'd1;
    end else if (dec && (ctr_r != BP_CTR_MIN)) begin
      ctr_r <= ctr_r - 2'd1;
    end else begin
      ctr_r <= ctr_r;
    end
  end

  assign ctr = ctr_r;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: same-cycle fetch prediction, training
// on execute-stage resolution, and a registered mispredict redirect.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_is_branch,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  input  logic        resolve_pred_taken,
  input  logic [31:0] resolve_pred_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] mispredict_count
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] valid_r;
  logic [TAG_W-1:0]   tag_r    [ENTRIES];
  logic [31:0]        target_r [ENTRIES];
  logic [1:0]         ctr_s    [ENTRIES];

  logic [IDX_W-1:0]   f_idx_s, r_idx_s;
  logic [TAG_W-1:0]   f_tag_s, r_tag_s;
  logic               f_hit_s, r_hit_s, r_taken_s;
  logic               upd_train_s, upd_alloc_s, upd_clear_s, mispredict_s;
  logic [ENTRIES-1:0] inc_vec_s, dec_vec_s, load_vec_s;

  logic               redirect_valid_r;
  logic [31:0]        redirect_pc_r;
  logic [31:0]        mispredict_count_r;

  assign f_idx_s = fetch_pc[IDX_W+1:2];
  assign f_tag_s = fetch_pc[31:IDX_W+2];
  assign r_idx_s = resolve_pc[IDX_W+1:2];
  assign r_tag_s = resolve_pc[31:IDX_W+2];

  // Lookup reads the registered table, so a same-cycle update is not yet visible.
  assign f_hit_s     = !reset_in && valid_r[f_idx_s] && (tag_r[f_idx_s] == f_tag_s);
  assign pred_taken  = f_hit_s && ctr_s[f_idx_s][1];
  assign pred_target = pred_taken ? target_r[f_idx_s] : next_seq_pc(fetch_pc);

  assign r_hit_s     = valid_r[r_idx_s] && (tag_r[r_idx_s] == r_tag_s);
  assign r_taken_s   = resolve_is_branch && resolve_taken;
  assign upd_train_s = resolve_valid && resolve_is_branch && r_hit_s;
  assign upd_alloc_s = resolve_valid && resolve_is_branch && !r_hit_s && resolve_taken;
  assign upd_clear_s = resolve_valid && !resolve_is_branch && r_hit_s;
  assign mispredict_s = resolve_valid &&
                        ((r_taken_s != resolve_pred_taken) ||
                         (r_taken_s && (resolve_target != resolve_pred_target)));

  // Per-entry counter controls, one-hot on the resolving index.
  always_comb begin
    inc_vec_s  = {ENTRIES{1'b0}};
    dec_vec_s  = {ENTRIES{1'b0}};
    load_vec_s = {ENTRIES{1'b0}};
    if (upd_train_s) begin
      if (resolve_taken) begin
        inc_vec_s[r_idx_s] = 1'b1;
      end else begin
        dec_vec_s[r_idx_s] = 1'b1;
      end
    end else if (upd_alloc_s) begin
      load_vec_s[r_idx_s] = 1'b1;
    end else begin
      load_vec_s = {ENTRIES{1'b0}};
    end
  end

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_ctr
    sat_counter2 u_ctr (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .inc      (inc_vec_s[gi]),
      .dec      (dec_vec_s[gi]),
      .load     (load_vec_s[gi]),
      .load_val (BP_CTR_WT),
      .ctr      (ctr_s[gi])
    );
  end

  // BTB valid/tag/target storage; a non-branch hit drops an aliased entry.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      valid_r <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        tag_r[i]    <= '0;
        target_r[i] <= 32'd0;
      end
    end else if (upd_alloc_s) begin
      valid_r[r_idx_s]  <= 1'b1;
      tag_r[r_idx_s]    <= r_tag_s;
      target_r[r_idx_s] <= resolve_target;
    end else if (upd_train_s && resolve_taken) begin
      target_r[r_idx_s] <= resolve_target;
    end else if (upd_clear_s) begin
      valid_r[r_idx_s] <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Redirect pulse, corrected PC and saturating mispredict counter.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      redirect_valid_r   <= 1'b0;
      redirect_pc_r      <= 32'd0;
      mispredict_count_r <= 32'd0;
    end else if (mispredict_s) begin
      redirect_valid_r <= 1'b1;
      redirect_pc_r    <= r_taken_s ? resolve_target : next_seq_pc(resolve_pc);
      if (mispredict_count_r != COUNT_MAX) begin
        mispredict_count_r <= mispredict_count_r + 32'd1;
      end else begin
        mispredict_count_r <= mispredict_count_r;
      end
    end else begin
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= redirect_pc_r;
    end
  end

  assign redirect_valid   = redirect_valid_r;
  assign redirect_pc      = redirect_pc_r;
  assign mispredict_count = mispredict_count_r;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage branch predictor and mispredict redirect unit for the MIPS pipeline. Looks up the fetch PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and supplies a predicted next PC. When the execute-stage branch evaluation resolves, it trains the table, detects mispredictions and issues a registered redirect to the PC/fetch logic.

## Interface
- `ENTRIES`, 16: BTB entries; power of two.
- `IDX_W`, 4: log2(ENTRIES).

Ports:
- `clk_in` in 1: single clock.
- `reset_in` in 1: asynchronous, active-high reset.
- `fetch_pc` in 32: PC being fetched this cycle.
- `pred_taken` out 1: prediction is taken.
- `pred_target` out 32: predicted next PC.
- `resolve_valid` in 1: an instruction resolves this cycle.
- `resolve_pc` in 32: PC of the resolving instruction.
- `resolve_is_branch` in 1: the instruction is a branch, jump or trap-class control transfer.
- `resolve_taken` in 1: actual outcome, the evaluator's branch decision.
- `resolve_target` in 32: actual target when taken.
- `resolve_pred_taken` in 1: prediction carried down the pipe with this instruction.
- `resolve_pred_target` in 32: predicted target carried down the pipe.
- `redirect_valid` out 1: registered one-cycle pulse; fetch must load `redirect_pc` and flush younger stages.
- `redirect_pc` out 32: corrected PC.
- `mispredict_count` out 32: saturating count of mispredictions.

## Operation
- Index = `pc[IDX_W+1:2]`. Tag = `pc[31:IDX_W+2]`.
- Each entry holds valid, tag, target[31:0] and ctr[1:0].
- **Lookup (combinational):**
  - hit = valid && tag match.
  - `pred_taken` = hit && ctr[1].
  - `pred_target` = `pred_taken` ? entry target : `fetch_pc` + 4.
  - The pipeline has no delay slot; fall-through is always +4.
- **Mispredict** = `resolve_valid` && ((`resolve_taken` != `resolve_pred_taken`) || (`resolve_taken` && `resolve_target` != `resolve_pred_target`)). For a non-branch, `resolve_taken` = 0.
- **Update** at the clock edge when `resolve_valid`:
  - Branch, hit: ctr increments if taken, decrements if not, saturating at 3 and 0. Target is written when taken.
  - Branch, miss, taken: allocate the entry, overwriting any existing one. valid = 1, new tag, target = `resolve_target`, ctr = 2'b10.
  - Branch, miss, not taken: no change.
  - Non-branch, hit: clear valid (alias removal).
- **Redirect:** on mispredict, the next edge sets `redirect_valid` = 1 and `redirect_pc` = `resolve_taken` ? `resolve_target` : `resolve_pc` + 4. Otherwise `redirect_valid` = 0 and `redirect_pc` holds its value.
- **Counter:** `mispredict_count` increments on each mispredict and holds at 32'hFFFF_FFFF.
- **Reset values:**
  - All valid bits 0, all ctr 2'b01, targets and tags 0.
  - `redirect_valid` 0, `redirect_pc` 0, `mispredict_count` 0.
  - Combinational outputs while in reset: `pred_taken` 0, `pred_target` = `fetch_pc` + 4.

## Timing
- Prediction latency is 0 cycles (same-cycle lookup).
- A table update becomes visible to lookup on the cycle after the resolving edge.
- Same-index lookup and update in one cycle: lookup returns the pre-update contents.
- Redirect latency is 1 cycle after `resolve_valid`. The pulse lasts exactly one cycle per mispredict.
- Back-to-back mispredicts produce back-to-back pulses; each `redirect_pc` reflects its own resolving instruction.
- 32-bit adds wrap modulo 2^32: PC 32'hFFFF_FFFC + 4 = 0.
- Asserting `reset_in` mid-operation clears the table, drops any pending redirect and zeroes the counter immediately, without waiting for a clock edge.

## Structure
- Shared package `mips_def.vh`: `OP_*`/`FUNC_*` constants (already present), plus new `BP_CTR_WNT` = 2'b01 and `BP_CTR_WT` = 2'b10.
- Natural sub-module `sat_counter2`: 2-bit saturating up/down counter with inc/dec/load. The BTB array stays inline as register vectors.

## Test plan
- Reset, then `fetch_pc` = 32'h0040_0010 → `pred_taken` 0, `pred_target` 32'h0040_0014, `redirect_valid` 0, `mispredict_count` 0.
- Resolve BEQ at 32'h0040_0010, taken, target 32'h0040_0100, predicted not-taken:
  - Next cycle `redirect_valid` 1 with `redirect_pc` 32'h0040_0100, count 1.
  - Lookup of 32'h0040_0010 then gives `pred_taken` 1, `pred_target` 32'h0040_0100.
- Same branch resolves not-taken three times from ctr 2'b10:
  - Prediction flips to not-taken after the first update.
  - ctr saturates at 0; the third resolve does not underflow.
  - Each mispredict redirects to 32'h0040_0014.
- Aliasing: 32'h0000_0010 and 32'h0000_0050 share index 4.
  - Allocating the second, taken, evicts the first; lookup of the first misses.
  - A non-branch resolve at 32'h0000_0050 clears valid.
- Lookup and update at the same index in one cycle → old prediction returned; new prediction the following cycle.
- `reset_in` asserted between `resolve_valid` and the redirect edge → no `redirect_valid` pulse, table empty.
